// File: rtl/interrupt_controller12_pkg.sv
// Shared constants and types for the 24-line interrupt controller.
// Holds line count, vector width, register map and FSM state type.
package processor12_pkg;

    localparam int N_IRQ  = 24;
    localparam int VEC_W  = 5;
    localparam int REG_W  = 12;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_IEN_LO  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IEN_HI  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_PEND_LO = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_PEND_HI = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/interrupt_controller12_if.sv
// Processor-side bus of the interrupt controller: register port
// (addr/we/wdata/rdata) and request handshake (req/vector/ack/eoi).
interface interrupt_controller12_if;
    import processor12_pkg::*;

    logic [ADDR_W-1:0] reg_addr;
    logic              reg_we;
    logic [REG_W-1:0]  reg_wdata;
    logic [REG_W-1:0]  reg_rdata;
    logic              int_req;
    logic [VEC_W-1:0]  int_vector;
    logic              int_ack;
    logic              int_eoi;

    modport master (
        output reg_addr, reg_we, reg_wdata, int_ack, int_eoi,
        input  reg_rdata, int_req, int_vector
    );

    modport slave (
        input  reg_addr, reg_we, reg_wdata, int_ack, int_eoi,
        output reg_rdata, int_req, int_vector
    );

endinterface

// File: rtl/interrupt_controller12_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser plus rising-edge
// detector. Ports: clk, rst (async active-low), irq_in, edge_pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // Arming chain: edges are ignored until the synchroniser and the
    // history flop have both been refilled after reset, so a line held
    // high across reset release never looks like a fresh edge.
    logic [SYNC_STAGES:0]   arm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            prev_q   <= sync_q[SYNC_STAGES-1];
            arm_q[0] <= 1'b1;
            for (int k = 1; k <= SYNC_STAGES; k++)
                arm_q[k] <= arm_q[k-1];
        end
    end

    assign edge_pulse = arm_q[SYNC_STAGES]
                      & sync_q[SYNC_STAGES-1]
                      & ~prev_q;

endmodule

// File: rtl/interrupt_controller12.sv
// Edge-triggered interrupt controller with enable/pending registers,
// fixed priority (line 0 highest) and a REQ/ack/eoi handshake.
// Ports: clk, rst (async active-low), irq_in[N_IRQ], bus (slave).
module interrupt_controller12 #(
    parameter int N_IRQ       = processor12_pkg::N_IRQ,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IRQ-1:0]         irq_in,
    interrupt_controller12_if.slave  bus
);
    import processor12_pkg::*;

    localparam int LINES = 2 * REG_W;

    logic [N_IRQ-1:0] edge_hit;
    logic [LINES-1:0] edge_w;
    logic [LINES-1:0] w1c;
    logic [LINES-1:0] ien_q;
    logic [LINES-1:0] pend_q;
    logic [LINES-1:0] pend_d;
    logic [LINES-1:0] cand;
    logic [VEC_W-1:0] cand_idx;
    logic             cand_vld;
    logic             ack_take;
    irq_state_t       state_q;
    irq_state_t       state_d;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_d;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk        (clk),
            .rst        (rst),
            .irq_in     (irq_in[i]),
            .edge_pulse (edge_hit[i])
        );
    end

    always_comb begin
        edge_w = '0;
        edge_w[N_IRQ-1:0] = edge_hit;
    end

    always_comb begin
        w1c = '0;
        if (bus.reg_we) begin
            unique case (bus.reg_addr)
                ADDR_PEND_LO: w1c[REG_W-1:0]     = bus.reg_wdata;
                ADDR_PEND_HI: w1c[LINES-1:REG_W] = bus.reg_wdata;
                default: ;
            endcase
        end
    end

    assign ack_take = (state_q == ST_REQ) && bus.int_ack;

    // Clears first, then new edges: a set in the same cycle wins.
    always_comb begin
        pend_d = pend_q & ~w1c;
        if (ack_take)
            pend_d[vec_q] = 1'b0;
        pend_d = pend_d | edge_w;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ien_q  <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (bus.reg_we && bus.reg_addr == ADDR_IEN_LO)
                ien_q[REG_W-1:0] <= bus.reg_wdata;
            if (bus.reg_we && bus.reg_addr == ADDR_IEN_HI)
                ien_q[LINES-1:REG_W] <= bus.reg_wdata;
        end
    end

    // Priority encoder: scan downward so the lowest index wins.
    always_comb begin
        cand     = pend_q & ien_q;
        cand_vld = |cand;
        cand_idx = '0;
        for (int i = LINES - 1; i >= 0; i--)
            if (cand[i])
                cand_idx = i[VEC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cand_vld) begin
                    state_d = ST_REQ;
                    vec_d   = cand_idx;
                end
            end
            ST_REQ: begin
                if (bus.int_ack)
                    state_d = ST_SERVICE;
                else if (w1c[vec_q])
                    state_d = ST_IDLE;
            end
            ST_SERVICE: begin
                if (bus.int_eoi)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.int_req    = (state_q == ST_REQ);
    assign bus.int_vector = vec_q;

    always_comb begin
        bus.reg_rdata = '0;
        unique case (bus.reg_addr)
            ADDR_IEN_LO:  bus.reg_rdata = ien_q[REG_W-1:0];
            ADDR_IEN_HI:  bus.reg_rdata = ien_q[LINES-1:REG_W];
            ADDR_PEND_LO: bus.reg_rdata = pend_q[REG_W-1:0];
            ADDR_PEND_HI: bus.reg_rdata = pend_q[LINES-1:REG_W];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller12.sv
// Directed self-checking bench for interrupt_controller12.
// Drives the bus as master; expected values are hand-computed.
module tb_interrupt_controller12;
    import processor12_pkg::*;

    logic        clk;
    logic        rst;
    logic [23:0] irq_in;
    int          total;
    int          bad;

    interrupt_controller12_if bus();

    interrupt_controller12 #(
        .N_IRQ       (24),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      input logic [11:0] exp);
        bus.reg_addr = a;
        #1;
        chk(tag, {20'd0, bus.reg_rdata}, {20'd0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [11:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_we    = 1'b1;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic eoi();
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
    endtask

    task automatic req_is(input string tag, input logic r,
                          input logic [4:0] v);
        chk({tag, "_req"}, {31'd0, bus.int_req}, {31'd0, r});
        if (r)
            chk({tag, "_vec"}, {27'd0, bus.int_vector}, {27'd0, v});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        irq_in = '0;
        bus.reg_addr  = '0;
        bus.reg_we    = 1'b0;
        bus.reg_wdata = '0;
        bus.int_ack   = 1'b0;
        bus.int_eoi   = 1'b0;
        tick(2);
        chk("rst_req", {31'd0, bus.int_req}, 32'd0);
        chk("rst_vec", {27'd0, bus.int_vector}, 32'd0);
        rd("rst_pend_lo", ADDR_PEND_LO, 12'h000);
        rd("rst_ien_lo", ADDR_IEN_LO, 12'h000);
        rst = 1'b1;
        tick(5);

        // Masked line still shows up as pending.
        irq_in[5] = 1'b1;
        tick(2);
        rd("lat_early", ADDR_PEND_LO, 12'h000);
        tick();
        rd("masked_pend", ADDR_PEND_LO, 12'h020);
        tick(2);
        req_is("masked", 1'b0, 5'd0);
        irq_in[5] = 1'b0;
        wr(ADDR_IEN_LO, 12'h020);
        tick();
        req_is("unmask", 1'b1, 5'd5);
        ack();
        req_is("ack5", 1'b0, 5'd0);
        rd("ack5_pend", ADDR_PEND_LO, 12'h000);
        eoi();
        tick();
        req_is("idle5", 1'b0, 5'd0);

        // Simultaneous 3 and 17: 3 wins, 17 follows after eoi.
        wr(ADDR_IEN_LO, 12'hfff);
        wr(ADDR_IEN_HI, 12'hfff);
        irq_in[3]  = 1'b1;
        irq_in[17] = 1'b1;
        tick(4);
        req_is("pri3", 1'b1, 5'd3);
        ack();
        rd("pri_pend_lo", ADDR_PEND_LO, 12'h000);
        rd("pri_pend_hi", ADDR_PEND_HI, 12'h020);
        req_is("svc3", 1'b0, 5'd0);
        eoi();
        req_is("eoi3", 1'b0, 5'd0);
        tick();
        req_is("next17", 1'b1, 5'd17);

        // Higher priority arrival must not disturb a live request.
        irq_in[2] = 1'b1;
        tick(5);
        req_is("hold17", 1'b1, 5'd17);
        rd("hold_pend_lo", ADDR_PEND_LO, 12'h004);
        ack();
        eoi();
        tick();
        req_is("next2", 1'b1, 5'd2);
        ack();
        eoi();
        irq_in = '0;
        tick(4);
        req_is("quiet", 1'b0, 5'd0);

        // W1C of the requested line withdraws the request.
        irq_in[4] = 1'b1;
        tick(4);
        req_is("req4", 1'b1, 5'd4);
        wr(ADDR_PEND_LO, 12'h010);
        req_is("w1c4", 1'b0, 5'd0);
        rd("w1c4_pend", ADDR_PEND_LO, 12'h000);
        irq_in[4] = 1'b0;
        tick(3);
        irq_in[4] = 1'b1;
        tick(4);
        req_is("req4b", 1'b1, 5'd4);
        bus.int_ack = 1'b1;
        wr(ADDR_PEND_LO, 12'h010);
        bus.int_ack = 1'b0;
        req_is("ackw1c", 1'b0, 5'd0);
        // A new pending line during SERVICE stays unrequested.
        irq_in[6] = 1'b1;
        tick(4);
        rd("svc_pend6", ADDR_PEND_LO, 12'h040);
        req_is("svc_block", 1'b0, 5'd0);
        eoi();
        tick();
        req_is("next6", 1'b1, 5'd6);
        ack();
        eoi();
        irq_in = '0;
        tick(4);

        // Edge and W1C on bit 0 in the same cycle: set wins.
        irq_in[0] = 1'b1;
        tick(2);
        wr(ADDR_PEND_LO, 12'h001);
        rd("setwin", ADDR_PEND_LO, 12'h001);
        tick();
        req_is("req0", 1'b1, 5'd0);
        ack();
        eoi();
        irq_in = '0;
        tick(4);

        // Reset mid-SERVICE with line 9 held high throughout.
        irq_in[9] = 1'b1;
        tick(4);
        req_is("req9", 1'b1, 5'd9);
        ack();
        rst = 1'b0;
        #1;
        req_is("rst_async", 1'b0, 5'd0);
        tick(2);
        rst = 1'b1;
        tick(8);
        rd("rst9_ien", ADDR_IEN_LO, 12'h000);
        rd("rst9_pend_lo", ADDR_PEND_LO, 12'h000);
        wr(ADDR_IEN_LO, 12'hfff);
        tick(3);
        rd("rst9_pend_lo2", ADDR_PEND_LO, 12'h000);
        rd("rst9_pend_hi", ADDR_PEND_HI, 12'h000);
        req_is("rst9_noreq", 1'b0, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
